// File: rtl/uart_imem_loader_if.sv
// Instruction-memory write port between the UART program loader (master)
// and the imem write side (slave).
interface uart_imem_loader_if #(
    parameter int ADDR_WIDTH = 9
);
    logic [ADDR_WIDTH-1:0] imem_write_address;
    logic [31:0]           imem_write_data;
    logic                  imem_write_enable;

    modport master (
        output imem_write_address,
        output imem_write_data,
        output imem_write_enable
    );

    modport slave (
        input imem_write_address,
        input imem_write_data,
        input imem_write_enable
    );
endinterface

// File: rtl/uart_imem_loader.sv
// 8N1 UART receiver feeding a frame parser that writes 32-bit words into imem
// and holds the core in reset while a load is in flight.
module uart_imem_loader #(
    parameter int CLOCK_HZ   = 27_000_000,
    parameter int BAUD       = 115200,
    parameter int ADDR_WIDTH = 9
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               uart_rx,
    uart_imem_loader_if.master imem,
    output logic               core_hold,
    output logic [7:0]         rx_data,
    output logic               rx_valid,
    output logic               frame_error,
    output logic               load_done,
    output logic               load_error
);
    localparam int DIVISOR = CLOCK_HZ / BAUD;
    localparam int CNT_W   = $clog2(DIVISOR);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIVISOR - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIVISOR / 2 - 1);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
    typedef enum logic [2:0] {L_IDLE, L_LEN0, L_LEN1, L_DATA, L_SUM} ld_state_t;

    logic             rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d;
    rx_state_t        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             frame_error_q, frame_error_d;

    ld_state_t             ld_state_q, ld_state_d;
    logic                  hold_q, hold_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic [23:0]           word_q, word_d;
    logic [1:0]            idx_q, idx_d;
    logic [15:0]           count_q, count_d;
    logic [7:0]            len_lo_q, len_lo_d;
    logic [7:0]            sum_q, sum_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            rx_meta_q     <= 1'b1;
            rx_sync_q     <= 1'b1;
            rx_state_q    <= RX_IDLE;
            cnt_q         <= '0;
            bit_q         <= '0;
            shift_q       <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            frame_error_q <= 1'b0;
            ld_state_q    <= L_IDLE;
            hold_q        <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            we_q          <= 1'b0;
            word_q        <= '0;
            idx_q         <= '0;
            count_q       <= '0;
            len_lo_q      <= '0;
            sum_q         <= '0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            rx_meta_q     <= rx_meta_d;
            rx_sync_q     <= rx_sync_d;
            rx_state_q    <= rx_state_d;
            cnt_q         <= cnt_d;
            bit_q         <= bit_d;
            shift_q       <= shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            frame_error_q <= frame_error_d;
            ld_state_q    <= ld_state_d;
            hold_q        <= hold_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            we_q          <= we_d;
            word_q        <= word_d;
            idx_q         <= idx_d;
            count_q       <= count_d;
            len_lo_q      <= len_lo_d;
            sum_q         <= sum_d;
            done_q        <= done_d;
            error_q       <= error_d;
        end
    end

    // Receiver: sample mid-bit, re-arm in RX_IDLE right after the stop sample.
    always_comb begin
        rx_meta_d     = uart_rx;
        rx_sync_d     = rx_meta_q;
        rx_state_d    = rx_state_q;
        cnt_d         = cnt_q;
        bit_d         = bit_q;
        shift_d       = shift_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        frame_error_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_sync_q) begin
                    rx_state_d = RX_START;
                    cnt_d      = '0;
                end
            end
            RX_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d      = '0;
                    bit_d      = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) rx_state_d = RX_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d = '0;
                    if (rx_sync_q) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        frame_error_d = 1'b1;
                        rx_state_d    = RX_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_BREAK: begin
                if (rx_sync_q) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Loader: the address advances on the edge after each write strobe.
    always_comb begin
        ld_state_d = ld_state_q;
        hold_d     = hold_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        word_d     = word_q;
        idx_d      = idx_q;
        count_d    = count_q;
        len_lo_d   = len_lo_q;
        sum_d      = sum_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
        if (we_q) addr_d = addr_q + 1'b1;
        if (frame_error_q && ld_state_q != L_IDLE) begin
            error_d    = 1'b1;
            ld_state_d = L_IDLE;
        end else if (rx_valid_q) begin
            case (ld_state_q)
                L_IDLE: begin
                    if (rx_data_q == 8'hA5) begin
                        hold_d     = 1'b1;
                        sum_d      = '0;
                        addr_d     = '0;
                        ld_state_d = L_LEN0;
                    end
                end
                L_LEN0: begin
                    len_lo_d   = rx_data_q;
                    ld_state_d = L_LEN1;
                end
                L_LEN1: begin
                    count_d    = {rx_data_q, len_lo_q};
                    idx_d      = '0;
                    ld_state_d = ({rx_data_q, len_lo_q} == 16'd0) ? L_SUM : L_DATA;
                end
                L_DATA: begin
                    sum_d = sum_q + rx_data_q;
                    idx_d = idx_q + 2'd1;
                    case (idx_q)
                        2'd0: word_d[7:0]   = rx_data_q;
                        2'd1: word_d[15:8]  = rx_data_q;
                        2'd2: word_d[23:16] = rx_data_q;
                        default: begin
                            wdata_d = {rx_data_q, word_q};
                            we_d    = 1'b1;
                            count_d = count_q - 16'd1;
                            if (count_q == 16'd1) ld_state_d = L_SUM;
                        end
                    endcase
                end
                L_SUM: begin
                    if (rx_data_q == sum_q) begin
                        done_d = 1'b1;
                        hold_d = 1'b0;
                    end else begin
                        error_d = 1'b1;
                    end
                    ld_state_d = L_IDLE;
                end
                default: ld_state_d = L_IDLE;
            endcase
        end
    end

    assign imem.imem_write_address = addr_q;
    assign imem.imem_write_data    = wdata_q;
    assign imem.imem_write_enable  = we_q;
    assign core_hold               = hold_q;
    assign rx_data                 = rx_data_q;
    assign rx_valid                = rx_valid_q;
    assign frame_error             = frame_error_q;
    assign load_done               = done_q;
    assign load_error              = error_q;
endmodule

// File: tb/tb_uart_imem_loader.sv
// Bench for uart_imem_loader: serial byte driver, event monitor and a
// frame-level model of the expected imem writes and load outcome.
`timescale 1ns/1ps
module tb_uart_imem_loader;
    localparam int CLOCK_HZ   = 1_000_000;
    localparam int BAUD       = 100_000;
    localparam int ADDR_WIDTH = 4;
    localparam int DIV        = CLOCK_HZ / BAUD;
    localparam int DEPTH      = 1 << ADDR_WIDTH;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       uart_rx = 1'b1;
    logic       core_hold;
    logic [7:0] rx_data;
    logic       rx_valid, frame_error, load_done, load_error;

    uart_imem_loader_if #(.ADDR_WIDTH(ADDR_WIDTH)) imem_bus ();

    uart_imem_loader #(.CLOCK_HZ(CLOCK_HZ), .BAUD(BAUD), .ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clock(clock), .resetn(resetn), .uart_rx(uart_rx), .imem(imem_bus.master),
        .core_hold(core_hold), .rx_data(rx_data), .rx_valid(rx_valid),
        .frame_error(frame_error), .load_done(load_done), .load_error(load_error)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Event log filled by the monitor
    int                    cyc = 0;
    logic [7:0]            rx_log[$];
    logic [ADDR_WIDTH-1:0] wa_log[$];
    logic [31:0]           wd_log[$];
    int                    wr_lat[$];
    int fe_cnt, done_cnt, err_cnt, done_lat, err_rx_lat, err_fe_lat, hold_rise_lat;
    int last_rx_cyc = 0, fe_cyc = 0;
    logic hold_prev = 1'b0;

    // Frame model
    logic [31:0] exp_words[$];
    logic [7:0]  tx_q[$];

    always @(posedge clock) begin
        #1;
        cyc++;
        if (resetn) begin
            if (imem_bus.imem_write_enable) begin
                wa_log.push_back(imem_bus.imem_write_address);
                wd_log.push_back(imem_bus.imem_write_data);
                wr_lat.push_back(cyc - last_rx_cyc);
            end
            if (load_done) begin done_cnt++; done_lat = cyc - last_rx_cyc; end
            if (load_error) begin err_cnt++; err_rx_lat = cyc - last_rx_cyc; err_fe_lat = cyc - fe_cyc; end
            if (core_hold && !hold_prev) hold_rise_lat = cyc - last_rx_cyc;
            if (frame_error) begin fe_cnt++; fe_cyc = cyc; end
            if (rx_valid) begin rx_log.push_back(rx_data); last_rx_cyc = cyc; end
        end
        hold_prev = core_hold;
    end

    task automatic clear_logs();
        rx_log.delete(); wa_log.delete(); wd_log.delete(); wr_lat.delete();
        fe_cnt = 0; done_cnt = 0; err_cnt = 0;
        done_lat = -1; err_rx_lat = -1; err_fe_lat = -1; hold_rise_lat = -1;
    endtask

    // Called and returns on a falling clock edge, so bytes chain with no gap.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (DIV) @(negedge clock);
        for (int k = 0; k < 8; k++) begin
            uart_rx = b[k];
            repeat (DIV) @(negedge clock);
        end
        uart_rx = stop_bit;
        repeat (DIV) @(negedge clock);
        uart_rx = 1'b1;
    endtask

    task automatic send_tx(input int first, input int last, input int gap_max);
        for (int i = first; i <= last; i++) begin
            send_byte(tx_q[i], 1'b1);
            repeat ($urandom_range(gap_max, 0)) @(negedge clock);
        end
    endtask

    // Builds A5, N, little-endian words, checksum (+delta to corrupt it).
    task automatic make_frame(input logic [7:0] csum_delta);
        logic [7:0]  csum;
        logic [15:0] n;
        logic [31:0] w;
        csum = 8'd0;
        n = 16'(exp_words.size());
        tx_q.delete();
        tx_q.push_back(8'hA5);
        tx_q.push_back(n[7:0]);
        tx_q.push_back(n[15:8]);
        for (int i = 0; i < exp_words.size(); i++) begin
            w = exp_words[i];
            for (int k = 0; k < 4; k++) begin
                tx_q.push_back(w[8*k +: 8]);
                csum = csum + w[8*k +: 8];
            end
        end
        tx_q.push_back(csum + csum_delta);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        checks++; if (core_hold !== 1'b0) begin errors++; $display("FAIL reset_core_hold: got %b want 0", core_hold); end
        checks++; if (imem_bus.imem_write_address !== '0) begin errors++; $display("FAIL reset_addr: got %0h want 0", imem_bus.imem_write_address); end
        checks++; if (imem_bus.imem_write_data !== 32'd0) begin errors++; $display("FAIL reset_data: got %h want 0", imem_bus.imem_write_data); end
        checks++; if (rx_data !== 8'd0) begin errors++; $display("FAIL reset_rx_data: got %h want 0", rx_data); end
        checks++; if ({imem_bus.imem_write_enable, rx_valid, frame_error, load_done, load_error} !== 5'd0) begin
            errors++; $display("FAIL reset_strobes: got %b want 00000",
                {imem_bus.imem_write_enable, rx_valid, frame_error, load_done, load_error});
        end
        resetn = 1'b1;
        repeat (5) @(negedge clock);
    endtask

    task automatic test_single_byte();
        logic [7:0] b;
        for (int t = 0; t < 3; t++) begin
            b = (t == 0) ? 8'h3C : 8'($urandom_range(255, 0));
            if (b == 8'hA5) b = 8'h5A;
            clear_logs();
            send_byte(b, 1'b1);
            repeat (10) @(negedge clock);
            checks++; if (rx_log.size() != 1 || rx_log[0] !== b) begin
                errors++; $display("FAIL single_byte: got %0d strobes first %h want 1 strobe %h", rx_log.size(), (rx_log.size() > 0) ? rx_log[0] : 8'h00, b);
            end
            checks++; if (fe_cnt != 0 || wa_log.size() != 0 || core_hold !== 1'b0) begin
                errors++; $display("FAIL single_byte_side: fe=%0d writes=%0d hold=%b want 0 0 0", fe_cnt, wa_log.size(), core_hold);
            end
        end
    endtask

    task automatic test_good_load();
        int bad_lat;
        clear_logs();
        exp_words.delete();
        exp_words.push_back(32'h1234_5678);
        exp_words.push_back(32'hDEAD_BEEF);
        make_frame(8'd0);
        send_tx(0, tx_q.size() - 2, 0);
        checks++; if (core_hold !== 1'b1 || hold_rise_lat != 1) begin
            errors++; $display("FAIL good_hold_rise: hold=%b lat=%0d want 1 1", core_hold, hold_rise_lat);
        end
        send_tx(tx_q.size() - 1, tx_q.size() - 1, 0);
        repeat (10) @(negedge clock);
        checks++; if (wa_log.size() != 2) begin errors++; $display("FAIL good_write_count: got %0d want 2", wa_log.size()); end
        else begin
            checks++; if (wa_log[0] !== 4'd0 || wd_log[0] !== 32'h1234_5678) begin errors++; $display("FAIL good_write0: got (%0d,%h) want (0,12345678)", wa_log[0], wd_log[0]); end
            checks++; if (wa_log[1] !== 4'd1 || wd_log[1] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL good_write1: got (%0d,%h) want (1,deadbeef)", wa_log[1], wd_log[1]); end
        end
        bad_lat = 0;
        foreach (wr_lat[i]) if (wr_lat[i] != 1) bad_lat++;
        checks++; if (bad_lat != 0) begin errors++; $display("FAIL good_write_latency: got %0d late strobes want 0", bad_lat); end
        checks++; if (done_cnt != 1 || err_cnt != 0 || done_lat != 1) begin
            errors++; $display("FAIL good_done: done=%0d err=%0d lat=%0d want 1 0 1", done_cnt, err_cnt, done_lat);
        end
        checks++; if (core_hold !== 1'b0) begin errors++; $display("FAIL good_hold_fall: got %b want 0", core_hold); end
    endtask

    task automatic test_bad_checksum();
        clear_logs();
        exp_words.delete();
        exp_words.push_back(32'h1234_5678);
        exp_words.push_back(32'hDEAD_BEEF);
        make_frame(8'd1);
        send_tx(0, tx_q.size() - 1, 2);
        repeat (10) @(negedge clock);
        checks++; if (wa_log.size() != 2 || err_cnt != 1 || done_cnt != 0 || err_rx_lat != 1) begin
            errors++; $display("FAIL bad_sum: writes=%0d err=%0d done=%0d lat=%0d want 2 1 0 1", wa_log.size(), err_cnt, done_cnt, err_rx_lat);
        end
        checks++; if (core_hold !== 1'b1) begin errors++; $display("FAIL bad_sum_hold: got %b want 1", core_hold); end
        clear_logs();
        exp_words.delete();
        for (int i = 0; i < 3; i++) exp_words.push_back($urandom);
        make_frame(8'd0);
        send_tx(0, tx_q.size() - 1, 5);
        repeat (10) @(negedge clock);
        checks++; if (wa_log.size() != 3 || done_cnt != 1 || err_cnt != 0 || core_hold !== 1'b0) begin
            errors++; $display("FAIL bad_sum_recover: writes=%0d done=%0d err=%0d hold=%b want 3 1 0 0", wa_log.size(), done_cnt, err_cnt, core_hold);
        end
        for (int i = 0; i < 3 && i < wd_log.size(); i++) begin
            checks++; if (wd_log[i] !== exp_words[i] || wa_log[i] !== ADDR_WIDTH'(i)) begin
                errors++; $display("FAIL recover_write%0d: got (%0d,%h) want (%0d,%h)", i, wa_log[i], wd_log[i], i, exp_words[i]);
            end
        end
    endtask

    task automatic test_abort();
        clear_logs();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'($urandom_range(255, 0)), 1'b0);
        repeat (10) @(negedge clock);
        checks++; if (fe_cnt != 1 || err_cnt != 1 || err_fe_lat != 1) begin
            errors++; $display("FAIL abort_strobes: fe=%0d err=%0d lat=%0d want 1 1 1", fe_cnt, err_cnt, err_fe_lat);
        end
        checks++; if (wa_log.size() != 0 || done_cnt != 0 || core_hold !== 1'b1) begin
            errors++; $display("FAIL abort_state: writes=%0d done=%0d hold=%b want 0 0 1", wa_log.size(), done_cnt, core_hold);
        end
        checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL abort_rx_data_kept: got %h want 11", rx_data); end
        send_byte(8'h55, 1'b1);
        repeat (10) @(negedge clock);
        checks++; if (rx_log.size() != 5 || rx_log[rx_log.size() - 1] !== 8'h55 || fe_cnt != 1) begin
            errors++; $display("FAIL abort_rearm: bytes=%0d fe=%0d want 5 bytes ending 55, fe 1", rx_log.size(), fe_cnt);
        end
        checks++; if (core_hold !== 1'b1) begin errors++; $display("FAIL abort_hold_sticky: got %b want 1", core_hold); end
    endtask

    task automatic test_wrap();
        logic [31:0] img[DEPTH];
        clear_logs();
        exp_words.delete();
        for (int i = 0; i < 17; i++) exp_words.push_back($urandom);
        make_frame(8'd0);
        send_tx(0, tx_q.size() - 1, 3);
        repeat (10) @(negedge clock);
        checks++; if (wa_log.size() != 17) begin errors++; $display("FAIL wrap_count: got %0d want 17", wa_log.size()); end
        for (int i = 0; i < 17 && i < wa_log.size(); i++) begin
            checks++; if (wa_log[i] !== ADDR_WIDTH'(i % DEPTH) || wd_log[i] !== exp_words[i]) begin
                errors++; $display("FAIL wrap_write%0d: got (%0d,%h) want (%0d,%h)", i, wa_log[i], wd_log[i], i % DEPTH, exp_words[i]);
            end
        end
        foreach (img[a]) img[a] = 32'd0;
        foreach (wa_log[i]) img[wa_log[i]] = wd_log[i];
        checks++; if (img[0] !== exp_words[16] || img[1] !== exp_words[1]) begin
            errors++; $display("FAIL wrap_image: got %h %h want %h %h", img[0], img[1], exp_words[16], exp_words[1]);
        end
        checks++; if (done_cnt != 1 || err_cnt != 0 || core_hold !== 1'b0) begin
            errors++; $display("FAIL wrap_done: done=%0d err=%0d hold=%b want 1 0 0", done_cnt, err_cnt, core_hold);
        end
    endtask

    task automatic test_glitch();
        clear_logs();
        uart_rx = 1'b0;
        repeat (3) @(negedge clock);
        uart_rx = 1'b1;
        repeat (30) @(negedge clock);
        checks++; if (rx_log.size() != 0 || fe_cnt != 0) begin
            errors++; $display("FAIL glitch: bytes=%0d fe=%0d want 0 0", rx_log.size(), fe_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] sent[$];
        logic [7:0] b;
        int bad;
        clear_logs();
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom_range(255, 0));
            if (b == 8'hA5) b = 8'h00;
            sent.push_back(b);
            send_byte(b, 1'b1);
        end
        repeat (10) @(negedge clock);
        bad = 0;
        foreach (sent[i]) if (i >= rx_log.size() || rx_log[i] !== sent[i]) bad++;
        checks++; if (rx_log.size() != 8 || bad != 0) begin
            errors++; $display("FAIL back_to_back: got %0d bytes, %0d wrong, want 8 bytes, 0 wrong", rx_log.size(), bad);
        end
        checks++; if (fe_cnt != 0 || core_hold !== 1'b0) begin
            errors++; $display("FAIL back_to_back_side: fe=%0d hold=%b want 0 0", fe_cnt, core_hold);
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_logs();
        exp_words.delete();
        for (int i = 0; i < 3; i++) exp_words.push_back($urandom | 32'h0000_0100);
        make_frame(8'd0);
        send_tx(0, 7, 0);
        repeat (3) @(negedge clock);
        checks++; if (core_hold !== 1'b1 || wa_log.size() != 1) begin
            errors++; $display("FAIL midreset_pre: hold=%b writes=%0d want 1 1", core_hold, wa_log.size());
        end
        resetn = 1'b0;
        repeat (2) @(negedge clock);
        checks++; if (core_hold !== 1'b0 || imem_bus.imem_write_address !== '0 || imem_bus.imem_write_data !== 32'd0 || rx_data !== 8'd0) begin
            errors++; $display("FAIL midreset_values: hold=%b addr=%0d data=%h rx=%h want 0 0 0 0",
                core_hold, imem_bus.imem_write_address, imem_bus.imem_write_data, rx_data);
        end
        resetn = 1'b1;
        @(posedge clock); #1;
        checks++; if ({imem_bus.imem_write_enable, rx_valid, load_done, load_error} !== 4'd0) begin
            errors++; $display("FAIL midreset_release_strobes: got %b want 0000",
                {imem_bus.imem_write_enable, rx_valid, load_done, load_error});
        end
        @(negedge clock);
        clear_logs();
        exp_words.delete();
        exp_words.push_back(32'hA5A5_A5A5);
        exp_words.push_back($urandom);
        make_frame(8'd0);
        send_tx(0, tx_q.size() - 1, 1);
        repeat (10) @(negedge clock);
        checks++; if (wa_log.size() != 2 || done_cnt != 1 || err_cnt != 0 || core_hold !== 1'b0) begin
            errors++; $display("FAIL reload: writes=%0d done=%0d err=%0d hold=%b want 2 1 0 0", wa_log.size(), done_cnt, err_cnt, core_hold);
        end else begin
            checks++; if (wa_log[0] !== 4'd0 || wd_log[0] !== 32'hA5A5_A5A5 || wa_log[1] !== 4'd1 || wd_log[1] !== exp_words[1]) begin
                errors++; $display("FAIL reload_writes: got (%0d,%h) (%0d,%h) want (0,a5a5a5a5) (1,%h)",
                    wa_log[0], wd_log[0], wa_log[1], wd_log[1], exp_words[1]);
            end
        end
    endtask

    initial begin
        clear_logs();
        test_reset();
        test_single_byte();
        test_good_load();
        test_bad_checksum();
        test_abort();
        test_wrap();
        test_glitch();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
